// File: rtl/sz_type_packer.sv
// sz_type_packer: packs 2-bit SZ type codes LSB-first into 32-bit words,
// buffered in a small FIFO behind a valid/ready handshake, with block flush.
// Ports: clk, rst_n (async, active low); code_in/code_valid (no backpressure);
//   flush (closes current word as last of block); word_out/word_count/
//   word_last/word_valid/word_ready (FIFO head handshake); fifo_level;
//   overflow (sticky dropped-word flag).
// Optional: define SZ_PACK_STATS_EN to add stat_codes/stat_words counters.
module sz_type_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    code_in,
    input  logic                          code_valid,
    input  logic                          flush,
    output logic [31:0]                   word_out,
    output logic [4:0]                    word_count,
    output logic                          word_last,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
`ifdef SZ_PACK_STATS_EN
    ,
    output logic [31:0]                   stat_codes,
    output logic [31:0]                   stat_words
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0] acc;
    logic [4:0]  n;

    logic [31:0] code_sh;
    logic [31:0] next_data;
    logic [4:0]  next_cnt;
    logic        close;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    logic [31:0] mem_data [FIFO_DEPTH];
    logic [4:0]  mem_cnt  [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];

    // The word being closed already includes a code accepted this cycle,
    // so a flush coinciding with the 16th code yields one count-16 word.
    always_comb begin
        code_sh   = {30'd0, code_in} << {n[3:0], 1'b0};
        next_data = code_valid ? (acc | code_sh) : acc;
        next_cnt  = n + {4'd0, code_valid};
        close     = flush || (code_valid && (n == 5'd15));
    end

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop    = !empty && word_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can
    // still take the new word (it lands in the slot being vacated).
    assign push   = close && (!full || pop);
    assign drop   = close && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            n        <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (close) begin
                acc <= '0;
                n   <= '0;
            end else begin
                acc <= next_data;
                n   <= next_cnt;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_idx] <= next_data;
            mem_cnt[wr_idx]  <= next_cnt;
            mem_last[wr_idx] <= flush;
        end
    end

    assign word_valid = !empty;
    assign word_out   = empty ? 32'd0 : mem_data[rd_idx];
    assign word_count = empty ? 5'd0  : mem_cnt[rd_idx];
    assign word_last  = empty ? 1'b0  : mem_last[rd_idx];
    assign fifo_level = wr_ptr - rd_ptr;

`ifdef SZ_PACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_codes <= '0;
            stat_words <= '0;
        end else begin
            if (code_valid) stat_codes <= stat_codes + 32'd1;
            if (push)       stat_words <= stat_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sz_type_packer.sv
// tb_sz_type_packer: directed table-driven bench for sz_type_packer,
// plus hand-written sequences for backpressure, overflow and reset.
module tb_sz_type_packer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  code_in;
    logic        code_valid;
    logic        flush;
    logic [31:0] word_out;
    logic [4:0]  word_count;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef SZ_PACK_STATS_EN
    logic [31:0] stat_codes;
    logic [31:0] stat_words;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sz_type_packer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .flush      (flush),
        .word_out   (word_out),
        .word_count (word_count),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef SZ_PACK_STATS_EN
        ,
        .stat_codes (stat_codes),
        .stat_words (stat_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ncodes;
        logic [31:0] pat;
        int          fmode;   // 0 none, 1 flush after, 2 flush on last code
        logic [31:0] exp_word;
        logic [4:0]  exp_cnt;
        logic        exp_last;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] c, input logic f);
        code_in    = c;
        code_valid = 1'b1;
        flush      = f;
        tick();
        code_valid = 1'b0;
        flush      = 1'b0;
        code_in    = 2'd0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, "_word"},  word_out, 32'd0);
        chk({tag, "_count"}, {27'd0, word_count}, 32'd0);
        chk({tag, "_last"},  {31'd0, word_last}, 32'd0);
        chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    logic [31:0] drain_exp [4];

    initial begin
        rst_n      = 1'b0;
        code_in    = 2'd0;
        code_valid = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;

        vecs[0] = '{16, 32'h55555555, 0, 32'h55555555, 5'd16, 1'b0};
        vecs[1] = '{16, 32'hE4E4E4E4, 0, 32'hE4E4E4E4, 5'd16, 1'b0};
        vecs[2] = '{16, 32'hE4E4E4E4, 0, 32'hE4E4E4E4, 5'd16, 1'b0};
        vecs[3] = '{5,  32'hFFFFFFFF, 1, 32'h000003FF, 5'd5,  1'b1};
        vecs[4] = '{0,  32'h00000000, 1, 32'h00000000, 5'd0,  1'b1};
        vecs[5] = '{16, 32'hAAAAAAAA, 2, 32'hAAAAAAAA, 5'd16, 1'b1};
        vecs[6] = '{3,  32'hFFFFFF39, 2, 32'h00000039, 5'd3,  1'b1};
        vecs[7] = '{1,  32'h00000002, 2, 32'h00000002, 5'd1,  1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // 16th code together with flush: one count-16 last word
        word_ready = 1'b1;
        for (int j = 0; j < 15; j++) feed(2'b11, 1'b0);
        chk("f16_pre_valid", {31'd0, word_valid}, 32'd0);
        feed(2'b11, 1'b1);
        chk("f16_valid", {31'd0, word_valid}, 32'd1);
        chk("f16_word", word_out, 32'hFFFFFFFF);
        chk("f16_count", {27'd0, word_count}, 32'd16);
        chk("f16_last", {31'd0, word_last}, 32'd1);
`ifdef SZ_PACK_STATS_EN
        chk("f16_stat_codes", stat_codes, 32'd16);
        chk("f16_stat_words", stat_words, 32'd1);
`endif
        tick();
        chk("f16_popped", {31'd0, word_valid}, 32'd0);
        word_ready = 1'b0;

        // table of single-word cases, held at head then popped
        for (int i = 0; i < 8; i++) begin
            word_ready = 1'b0;
            for (int j = 0; j < vecs[i].ncodes; j++)
                feed(vecs[i].pat[2*j +: 2],
                     (vecs[i].fmode == 2) && (j == vecs[i].ncodes - 1));
            if (vecs[i].fmode == 1) do_flush();
            chk($sformatf("v%0d_valid", i), {31'd0, word_valid}, 32'd1);
            chk($sformatf("v%0d_word", i), word_out, vecs[i].exp_word);
            chk($sformatf("v%0d_count", i), {27'd0, word_count},
                {27'd0, vecs[i].exp_cnt});
            chk($sformatf("v%0d_last", i), {31'd0, word_last},
                {31'd0, vecs[i].exp_last});
            chk($sformatf("v%0d_level", i), {29'd0, fifo_level}, 32'd1);
            word_ready = 1'b1;
            tick();
            word_ready = 1'b0;
            chk($sformatf("v%0d_empty", i), {31'd0, word_valid}, 32'd0);
        end

        // backpressure: 5 words, 5th dropped
        drain_exp[0] = 32'h55555555;
        drain_exp[1] = 32'hAAAAAAAA;
        drain_exp[2] = 32'hFFFFFFFF;
        drain_exp[3] = 32'h00000000;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++) feed(2'((k + 1) % 4), 1'b0);
        chk("bp_level4", {29'd0, fifo_level}, 32'd4);
        chk("bp_ovf_pre", {31'd0, overflow}, 32'd0);
        for (int j = 0; j < 16; j++) feed(2'b01, 1'b0);
        chk("bp_level_full", {29'd0, fifo_level}, 32'd4);
        chk("bp_ovf", {31'd0, overflow}, 32'd1);
        chk("bp_head0", word_out, 32'h55555555);
        tick();
        tick();
        chk("bp_head_stable", word_out, 32'h55555555);
        chk("bp_cnt_stable", {27'd0, word_count}, 32'd16);
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'd0, word_valid}, 32'd1);
            chk($sformatf("drain%0d_word", i), word_out, drain_exp[i]);
            tick();
        end
        word_ready = 1'b0;
        chk("drain_empty", {31'd0, word_valid}, 32'd0);
        chk("drain_level", {29'd0, fifo_level}, 32'd0);
        chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

        // reset mid-word discards the partial word and clears overflow
        word_ready = 1'b1;
        for (int j = 0; j < 7; j++) feed(2'b10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rstmid");
        #1;
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 15; j++) feed(2'b10, 1'b0);
        chk("rst_pre_valid", {31'd0, word_valid}, 32'd0);
        feed(2'b10, 1'b0);
        chk("rst_valid", {31'd0, word_valid}, 32'd1);
        chk("rst_word", word_out, 32'hAAAAAAAA);
        chk("rst_count", {27'd0, word_count}, 32'd16);
        tick();
        chk("rst_popped", {31'd0, word_valid}, 32'd0);

        // push into full FIFO with simultaneous pop: no drop
        word_ready = 1'b0;
        for (int j = 0; j < 64; j++) feed(2'b01, 1'b0);
        for (int j = 0; j < 15; j++) feed(2'b11, 1'b0);
        chk("fp_full", {29'd0, fifo_level}, 32'd4);
        word_ready = 1'b1;
        feed(2'b11, 1'b0);
        word_ready = 1'b0;
        chk("fp_level", {29'd0, fifo_level}, 32'd4);
        chk("fp_no_ovf", {31'd0, overflow}, 32'd0);
        word_ready = 1'b1;
        repeat (3) tick();
        chk("fp_tail_word", word_out, 32'hFFFFFFFF);
        chk("fp_tail_level", {29'd0, fifo_level}, 32'd1);
        tick();
        word_ready = 1'b0;
        chk("fp_empty", {31'd0, word_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
